wm8731_i2c_responder: RTL

- Synthesizable I2C target that emulates the WM8731 2-wire control interface. It is the responder side of the codec controller's I2C write path.
- Decodes 3-byte write frames: device address + W, then {reg_addr[6:0], data[8]}, then data[7:0].
- ACKs each byte, holds a WM8731-style register file and reports every accepted write.
- Used as an RTL codec stand-in for closed-loop simulation and FPGA self-test of the controller.

---
 rtl/wm8731_i2c_responder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wm8731_i2c_responder.sv
// WM8731-style I2C write target: decodes {addr+W, {reg[6:0],d[8]}, d[7:0]} frames,
// ACKs each byte and maintains a 10-entry, 9-bit register file.
module wm8731_i2c_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk50MHz,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr_valid,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_ACK_A  = 3'd2;
    localparam logic [2:0] S_BYTE1  = 3'd3;
    localparam logic [2:0] S_ACK_1  = 3'd4;
    localparam logic [2:0] S_BYTE2  = 3'd5;
    localparam logic [2:0] S_ACK_2  = 3'd6;
    localparam logic [2:0] S_IGNORE = 3'd7;
    localparam int         NUM_REGS = 10;

    function automatic logic [8:0] reg_default(input int idx);
        case (idx)
            0, 1:    reg_default = 9'h097;
            2, 3:    reg_default = 9'h079;
            4:       reg_default = 9'h00A;
            5:       reg_default = 9'h008;
            6:       reg_default = 9'h09F;
            7:       reg_default = 9'h00A;
            default: reg_default = 9'h000;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [2:0] state_q, state_d, bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d, frame_err_q, frame_err_d;
    logic [6:0] wr_addr_q, wr_addr_d, lat_addr_q, lat_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic       lat_d8_q, lat_d8_d;
    logic [8:0] regs_q [NUM_REGS];
    logic [8:0] regs_d [NUM_REGS];

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, abort_err;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign abort_err = (state_q == S_BYTE1) || (state_q == S_ACK_1) || (state_q == S_BYTE2) ||
                       ((state_q == S_ADDR) && ((bit_cnt_q != 3'd0) || byte_done_q));

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        lat_addr_d  = lat_addr_q;
        lat_d8_d    = lat_d8_q;
        regs_d      = regs_q;

        if (stop_det) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            frame_err_d = abort_err;
        end else if (start_det) begin
            state_d     = S_ADDR;
            busy_d      = 1'b1;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
        end else if ((state_q == S_ADDR) || (state_q == S_BYTE1) || (state_q == S_BYTE2)) begin
            if (scl_rise && !byte_done_q) begin
                shift_d     = {shift_q[6:0], sda_s};
                bit_cnt_d   = bit_cnt_q + 3'd1;
                byte_done_d = (bit_cnt_q == 3'd7);
            end else if (scl_fall && byte_done_q) begin
                // A full byte is in shift_q; the ACK slot opens on this SCL low phase.
                byte_done_d = 1'b0;
                if (state_q == S_ADDR) begin
                    if (shift_q == {DEV_ADDR, 1'b0}) begin
                        state_d  = S_ACK_A;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end else if (state_q == S_BYTE1) begin
                    lat_addr_d = shift_q[7:1];
                    lat_d8_d   = shift_q[0];
                    state_d    = S_ACK_1;
                    sda_oe_d   = 1'b1;
                end else begin
                    state_d    = S_ACK_2;
                    sda_oe_d   = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = lat_addr_q;
                    wr_data_d  = {lat_d8_q, shift_q};
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (lat_addr_q == 7'd15)
                            regs_d[i] = reg_default(i);
                        else if (lat_addr_q == 7'(i))
                            regs_d[i] = {lat_d8_q, shift_q};
                    end
                end
            end
        end else if ((state_q == S_ACK_A) || (state_q == S_ACK_1) || (state_q == S_ACK_2)) begin
            if (scl_fall) begin
                sda_oe_d = 1'b0;
                state_d  = (state_q == S_ACK_A) ? S_BYTE1 :
                           (state_q == S_ACK_1) ? S_BYTE2 : S_IGNORE;
            end
        end
    end

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            // Idle bus is high; presetting the synchronizers avoids false edges after reset.
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            byte_done_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 9'd0;
            lat_addr_q  <= 7'd0;
            lat_d8_q    <= 1'b0;
            // NOTE: the register file is reset on purpose; the codec model must power up at defaults.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            lat_addr_q  <= lat_addr_d;
            lat_d8_q    <= lat_d8_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        rd_data = 9'h000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 4'(i)) rd_data = regs_q[i];
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign reg_wr_valid = wr_valid_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign frame_err    = frame_err_q;

endmodule
